// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage driving the IF/ID pipeline register
`timescale 1ns/1ps
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_INC   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_pc_out,
  output logic [31:0] o_ir_out,
  output logic        o_valid_out,
  output logic        o_if_id_enable,
  output logic        o_if_id_bubble
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pc_out;
  logic [31:0] r_ir_out;
  logic        r_valid_out;
  logic        r_kill;

  // A redirect in S_REQ suppresses the request so the stale PC never reaches memory.
  assign o_imem_req     = (r_state == S_REQ) && !i_redirect && i_rst_n;
  assign o_imem_addr    = r_pc;
  assign o_pc_out       = r_pc_out;
  assign o_ir_out       = r_ir_out;
  assign o_valid_out    = r_valid_out;
  assign o_if_id_enable = !i_stall;
  assign o_if_id_bubble = !r_valid_out || i_redirect;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_REQ;
      r_pc        <= RESET_PC;
      r_pc_out    <= 32'h0;
      r_ir_out    <= 32'h0;
      r_valid_out <= 1'b0;
      r_kill      <= 1'b0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (i_redirect) begin
            r_pc <= i_redirect_pc;
          end else if (i_imem_ready) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_imem_rvalid) begin
            if (r_kill || i_redirect) begin
              r_kill  <= 1'b0;
              r_state <= S_REQ;
              if (i_redirect) r_pc <= i_redirect_pc;
            end else begin
              r_ir_out    <= i_imem_rdata;
              r_pc_out    <= r_pc;
              r_valid_out <= 1'b1;
              r_pc        <= r_pc + PC_INC;
              r_state     <= S_HOLD;
            end
          end else if (i_redirect) begin
            // The in-flight response still has to drain; mark it for discard.
            r_pc   <= i_redirect_pc;
            r_kill <= 1'b1;
          end
        end
        S_HOLD: begin
          if (i_redirect) begin
            r_valid_out <= 1'b0;
            r_pc        <= i_redirect_pc;
            r_state     <= S_REQ;
          end else if (!i_stall) begin
            r_valid_out <= 1'b0;
            r_state     <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] pc_out;
  logic [31:0] ir_out;
  logic        valid_out;
  logic        if_id_enable;
  logic        if_id_bubble;

  fetch_unit #(.RESET_PC(32'h0000_0000), .PC_INC(4)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .o_imem_req     (imem_req),
    .o_imem_addr    (imem_addr),
    .i_imem_ready   (imem_ready),
    .i_imem_rvalid  (imem_rvalid),
    .i_imem_rdata   (imem_rdata),
    .i_stall        (stall),
    .i_redirect     (redirect),
    .i_redirect_pc  (redirect_pc),
    .o_pc_out       (pc_out),
    .o_ir_out       (ir_out),
    .o_valid_out    (valid_out),
    .o_if_id_enable (if_id_enable),
    .o_if_id_bubble (if_id_bubble)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] next_pc = 32'h0;
  int          mem_pend = 0;
  logic [31:0] mem_addr = 32'h0;
  int          lat = 1;
  bit          inject_stale = 1'b0;
  int          deliveries = 0;
  logic        last_bubble = 1'b0;
  logic [31:0] last_hs_addr = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs just after an edge, check, step, check the result.
  task automatic tick(input bit rdy, input bit stl, input bit rdr, input logic [31:0] rpc);
    logic        pv;
    logic [31:0] ppc;
    logic [31:0] pir;
    logic [31:0] hs_addr;
    bit          hs;
    pv  = valid_out;
    ppc = pc_out;
    pir = ir_out;
    imem_rvalid = (mem_pend == 1) || inject_stale;
    imem_rdata  = (mem_pend == 1) ? (mem_addr ^ 32'hA5A5_0000) : $urandom;
    imem_ready  = rdy;
    stall       = stl;
    redirect    = rdr;
    redirect_pc = rpc;
    #1;
    check("if_id_enable", 32'(if_id_enable), 32'(!stl));
    check("if_id_bubble", 32'(if_id_bubble), 32'(!pv || rdr));
    last_bubble = if_id_bubble;
    if (mem_pend > 0 || pv || rdr) check("req_low", 32'(imem_req), 32'h0);
    hs      = imem_req && rdy;
    hs_addr = imem_addr;
    if (hs) begin
      check("fetch_addr", imem_addr, next_pc);
      last_hs_addr = imem_addr;
    end
    @(posedge clk);
    #1;
    if (mem_pend > 0) mem_pend--;
    if (hs) begin
      mem_pend = lat;
      mem_addr = hs_addr;
    end
    if (rdr) begin
      check("redirect_clears_valid", 32'(valid_out), 32'h0);
      next_pc = rpc;
    end else if (pv) begin
      if (stl) begin
        check("stall_valid", 32'(valid_out), 32'h1);
        check("stall_pc", pc_out, ppc);
        check("stall_ir", ir_out, pir);
      end else begin
        check("consume_valid", 32'(valid_out), 32'h0);
      end
    end else if (valid_out) begin
      check("deliver_pc", pc_out, next_pc);
      check("deliver_ir", ir_out, next_pc ^ 32'hA5A5_0000);
      next_pc = next_pc + 32'd4;
      deliveries++;
    end
    if (!valid_out) begin
      check("retain_pc", pc_out, ppc);
      check("retain_ir", ir_out, pir);
    end
  endtask

  initial begin
    int d0;
    // reset state
    @(posedge clk);
    #1;
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(valid_out), 32'h0);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_ir_out", ir_out, 32'h0);
    check("rst_bubble", 32'(if_id_bubble), 32'h1);
    check("rst_enable", 32'(if_id_enable), 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // free run: one instruction every three cycles
    lat = 1;
    for (int k = 1; k <= 9; k++) begin
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      check("freerun_valid", 32'(valid_out), 32'((k % 3) == 2));
      if (k == 8) begin
        check("freerun_pc8", pc_out, 32'h8);
        check("freerun_ir8", ir_out, 32'hA5A5_0008);
      end
    end

    // memory not ready: request and address held
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      check("wait_ready_req", 32'(imem_req), 32'h1);
      check("wait_ready_addr", imem_addr, 32'hC);
    end
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    check("ready_edge1_valid", 32'(valid_out), 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    check("ready_edge2_valid", 32'(valid_out), 32'h1);
    check("ready_pc_out", pc_out, 32'hC);

    // stall holds the buffered instruction
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, 1'b1, 1'b0, 32'h0);
      check("stall_req", 32'(imem_req), 32'h0);
    end
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    check("post_stall_req", 32'(imem_req), 32'h1);
    check("post_stall_addr", imem_addr, 32'h10);

    // redirect while waiting: response discarded
    lat = 2;
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b1, 32'h100);
    check("wait_redir_addr", imem_addr, 32'h100);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    check("killed_valid", 32'(valid_out), 32'h0);
    lat = 1;
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    check("after_kill_pc", pc_out, 32'h100);

    // redirect beats stall in hold
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b1, 32'h40);
    check("hold_redir_bubble", 32'(last_bubble), 32'h1);
    check("hold_redir_addr", imem_addr, 32'h40);
    lat = 2;
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    check("hold_redir_req_addr", last_hs_addr, 32'h40);

    // asynchronous reset mid-wait, then a stale response
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(valid_out), 32'h0);
    check("async_rst_pc_out", pc_out, 32'h0);
    check("async_rst_ir_out", ir_out, 32'h0);
    check("async_rst_req", 32'(imem_req), 32'h0);
    check("async_rst_addr", imem_addr, 32'h0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    mem_pend = 0;
    next_pc  = 32'h0;
    inject_stale = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    inject_stale = 1'b0;
    check("stale_req", 32'(imem_req), 32'h1);
    check("stale_addr", imem_addr, 32'h0);
    check("stale_valid", 32'(valid_out), 32'h0);
    lat = 1;
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    check("post_rst_valid", 32'(valid_out), 32'h1);

    // randomized traffic against the program-order model
    d0 = deliveries;
    for (int k = 0; k < 800; k++) begin
      bit          rdy;
      bit          stl;
      bit          rdr;
      logic [31:0] rpc;
      lat = int'($urandom_range(1, 3));
      rdy = ($urandom % 4) != 0;
      stl = ($urandom % 4) == 0;
      rdr = ($urandom % 16) == 0;
      rpc = (($urandom % 4) == 0) ? 32'hFFFF_FFFC : {22'h0, 8'($urandom), 2'b00};
      tick(rdy, stl, rdr, rpc);
    end
    check("random_progress", 32'(deliveries - d0 >= 20), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage. It writes the IF/ID pipeline register: owns the PC, issues one instruction-memory read at a time over a req/ready + rvalid handshake, and buffers the returned word with its PC.
- Drives the pc/ir data into IF/ID, plus that register's enable and bubble controls.
- Honours stall from the hazard unit and redirect (taken branch/jump) from EX.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_INC, 4, byte increment added to the PC per sequential fetch.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_req  out  1  read request valid
- imem_addr  out  32  read address (current PC)
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid (one pulse per accepted request)
- imem_rdata  in  32  read data
- stall  in  1  downstream holds; IF/ID must not load
- redirect  in  1  flush and restart fetch
- redirect_pc  in  32  new fetch address
- pc_out  out  32  PC of buffered instruction (to IF/ID pc)
- ir_out  out  32  buffered instruction (to IF/ID ir)
- valid_out  out  1  pc_out/ir_out hold an undelivered instruction
- if_id_enable  out  1  = ~stall
- if_id_bubble  out  1  = ~valid_out | redirect

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values (async, while rst_n=0):
  - pc = RESET_PC
  - pc_out = 0, ir_out = 0, valid_out = 0
  - kill = 0, state = S_REQ
  - imem_req = 0 while in reset
- At most one memory request is outstanding.
- imem_addr = pc at all times.
- S_REQ:
  - imem_req = ~redirect.
  - redirect=1: pc <= redirect_pc; stay in S_REQ. No request is issued that cycle.
  - Otherwise, imem_ready=1: go to S_WAIT; pc is unchanged.
  - imem_ready=0: stay in S_REQ with request held. imem_addr must stay stable until accepted.
- S_WAIT (imem_req = 0):
  - redirect=1 without imem_rvalid: pc <= redirect_pc; kill <= 1.
  - imem_rvalid=1 with kill=1 or redirect=1: discard data; kill <= 0; go to S_REQ. If redirect=1, pc <= redirect_pc.
  - imem_rvalid=1 otherwise:
    - ir_out <= imem_rdata, pc_out <= pc, valid_out <= 1
    - pc <= pc + PC_INC (mod 2^32; 32'hFFFF_FFFC wraps to 0)
    - go to S_HOLD
- S_HOLD (imem_req = 0):
  - The instruction is consumed on an edge with valid_out=1 and stall=0. On that edge: valid_out <= 0; go to S_REQ.
  - stall=1: hold pc_out/ir_out/valid_out unchanged.
  - redirect=1: valid_out <= 0; pc <= redirect_pc; go to S_REQ. Redirect wins over consumption and stall.
- Priority: reset > redirect > rvalid/consume > stall.
- Latency:
  - With imem_ready=1 and single-cycle rvalid, valid_out rises 2 edges after imem_req first asserts.
  - Sequential throughput is 1 instruction per 3 cycles.
- pc_out/ir_out retain their last values when valid_out=0. Bubble handling belongs to IF/ID via if_id_bubble.
- imem_rvalid in S_REQ or S_HOLD is a protocol error. It is ignored and must not change state.

Test Plan:
- Reset then free-run; memory with ready=1, 1-cycle rvalid, rdata=addr^32'hA5A5_0000, stall=0 -> valid_out pulses. Delivered (pc_out, ir_out) = (0, 32'hA5A5_0000), (4, 32'hA5A5_0004), (8, 32'hA5A5_0008), 3 cycles apart.
- ready held 0 for 4 cycles on the first request -> imem_req stays 1 with imem_addr=0 throughout. valid_out rises 2 edges after ready finally asserts.
- stall=1 for 5 cycles while valid_out=1 with pc_out=4 -> pc_out/ir_out/valid_out unchanged. imem_req=0. if_id_enable=0. Fetch of 8 requested only after stall drops.
- redirect to 32'h0000_0100 while in S_WAIT (rvalid 2 cycles later) -> that response is discarded, valid_out stays 0. Next imem_addr=32'h100; next delivered pc_out=32'h100.
- redirect to 32'h40 while valid_out=1 and stall=1 -> valid_out=0 next cycle. if_id_bubble=1 during the redirect cycle. Next request addr=32'h40.
- rst_n pulled low mid-S_WAIT -> all outputs clear immediately. After release, first imem_addr=RESET_PC. A stale rvalid arriving after reset release in S_REQ is ignored.
